ping_pong_scheduler: RTL and testbench

Scheduler that shares one ping-pong counter between two requesters. Each requester asks for a run of N counter steps. The block arbitrates, drives the counter's enable for exactly N cycles, counts the direction reversals (bounces) seen during the run, and reports completion. It sits directly in front of the counter's `enable` input; the counter's reset stays under system control.

---
 rtl/pps_pkg.sv | 5 +
 rtl/pps_arbiter.sv | 23 ++
 rtl/ping_pong_scheduler.sv | 58 +++++
 tb/tb_ping_pong_scheduler.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pps_pkg.sv
// pps_pkg: shared state encoding and requester count for the ping-pong scheduler
package pps_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} pps_state_t;
  localparam int PPS_NREQ = 2;
endpackage

// File: rtl/pps_arbiter.sv
// pps_arbiter: picks the winning requester; fixed priority, or round-robin under PPS_ROUND_ROBIN_EN
// Ports: clk, rst (sync, active-high); i_req request vector; i_grant pulses when the
// winner is accepted (advances the round-robin pointer); o_win index of the winner.
module pps_arbiter import pps_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic [PPS_NREQ-1:0] i_req,
  input  logic                i_grant,
  output logic                o_win
);
`ifdef PPS_ROUND_ROBIN_EN
  // r_ptr holds the requester favoured on a tie: the one that did not win last
  logic r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= 1'b0;
    else if (i_grant) r_ptr <= ~o_win;
  always_comb o_win = (&i_req) ? r_ptr : i_req[1];
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, i_grant};
  always_comb o_win = ~i_req[0] & i_req[1];
`endif
endmodule

// File: rtl/ping_pong_scheduler.sv
// ping_pong_scheduler: grants a shared ping-pong counter to one of two requesters for N enable cycles
// Ports: clk, rst (sync, active-high); req[1:0] level requests; len0/len1 run lengths
// sampled at grant; cnt_direction counter direction; gnt one-hot grant; busy; cnt_enable;
// done pulse with done_id; bounces = saturating reversal count of the last run.
// Build option: define PPS_ROUND_ROBIN_EN for round-robin tie-breaking (fixed priority otherwise).
module ping_pong_scheduler import pps_pkg::*; #(
  parameter int LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PPS_NREQ-1:0] req,
  input  logic [LEN_W-1:0]    len0,
  input  logic [LEN_W-1:0]    len1,
  input  logic                cnt_direction,
  output logic [PPS_NREQ-1:0] gnt,
  output logic                busy,
  output logic                cnt_enable,
  output logic                done,
  output logic                done_id,
  output logic [LEN_W-1:0]    bounces
);
  pps_state_t       r_state, w_next;
  logic [LEN_W-1:0] r_remaining, r_bounces, w_len;
  logic             r_id, r_dir_q, w_win, w_grant;
  pps_arbiter u_arb (.clk(clk), .rst(rst), .i_req(req), .i_grant(w_grant), .o_win(w_win));
  assign w_grant = (r_state == IDLE) && (|req);
  assign w_len   = w_win ? len1 : len0;
  // a zero-length grant skips RUN so no enable is ever issued
  always_comb
    w_next = r_state == IDLE ? (w_grant ? (w_len == '0 ? DONE : RUN) : IDLE)
           : r_state == RUN  ? (r_remaining == LEN_W'(1) ? DONE : RUN)
           : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_bounces   <= '0;
      r_id        <= 1'b0;
      r_dir_q     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dir_q <= cnt_direction;
      if (w_grant) begin
        r_remaining <= w_len;
        r_id        <= w_win;
        r_bounces   <= '0;
      end else begin
        if (r_state == RUN) r_remaining <= r_remaining - LEN_W'(1);
        if (busy && cnt_direction != r_dir_q && !(&r_bounces)) r_bounces <= r_bounces + LEN_W'(1);
      end
    end
  assign busy       = r_state != IDLE;
  assign cnt_enable = r_state == RUN;
  assign done       = r_state == DONE;
  assign done_id    = done & r_id;
  assign gnt        = {busy & r_id, busy & ~r_id};
  assign bounces    = r_bounces;
endmodule

// File: tb/tb_ping_pong_scheduler.sv
// tb_ping_pong_scheduler: directed stimulus, per-cycle model comparison and literal test-plan checks
module tb_ping_pong_scheduler;
  import pps_pkg::*;
  logic       clk = 0, rst = 1, c_rst = 1, cnt_direction, done, done_id, busy, cnt_enable;
  logic [1:0] req = 0, gnt;
  logic [7:0] len0 = 0, len1 = 0, bounces;
  logic [3:0] c_out;
  logic       c_dir;
  logic [1:0] s_req = 0, s_gnt;
  logic [3:0] s_len0 = 0, s_bounces;
  logic       s_dir = 0, s_busy, s_en, s_done, s_did;
  int errors = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  ping_pong_scheduler #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1),
    .cnt_direction(cnt_direction), .gnt(gnt), .busy(busy), .cnt_enable(cnt_enable), .done(done),
    .done_id(done_id), .bounces(bounces));
  ping_pong_scheduler #(.LEN_W(4)) dut4 (.clk(clk), .rst(rst), .req(s_req), .len0(s_len0), .len1(4'd0),
    .cnt_direction(s_dir), .gnt(s_gnt), .busy(s_busy), .cnt_enable(s_en), .done(s_done),
    .done_id(s_did), .bounces(s_bounces));
  // attached 4-bit ping-pong counter, reversing at 15 and 0
  assign cnt_direction = c_dir;
  always @(posedge clk)
    if (c_rst) begin c_out <= 0; c_dir <= 0; end
    else if (cnt_enable) begin
      if (!c_dir) begin
        if (c_out == 15) begin c_dir <= 1; c_out <= 14; end else c_out <= c_out + 1;
      end else begin
        if (c_out == 0) begin c_dir <= 0; c_out <= 1; end else c_out <= c_out - 1;
      end
    end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  // model: a grant at edge t opens a window of len+1 cycles; offset p (1-based) within it
  // is an enable cycle for p<=len and the done cycle for p==len+1
  bit m_act = 0, m_id = 0, m_ptr = 0, m_dirq = 0, started = 0;
  int m_pos = 0, m_len = 0, m_bnc = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_bnc = 0; m_dirq = 0; m_ptr = 0; m_id = 0;
    end else begin
      if (m_act) begin
        if (cnt_direction != m_dirq && m_bnc < 255) m_bnc++;
        if (m_pos == m_len + 1) m_act = 0; else m_pos++;
      end else if (req != 0) begin
`ifdef PPS_ROUND_ROBIN_EN
        m_id = (req == 2'b11) ? m_ptr : req[1];
        m_ptr = !m_id;
`else
        m_id = !req[0];
`endif
        m_act = 1; m_pos = 1; m_bnc = 0;
        m_len = m_id ? int'(len1) : int'(len0);
      end
      m_dirq = cnt_direction;
    end
    cyc++;
    started = 1;
    #1;
    chk("gnt", int'(gnt), m_act ? (m_id ? 2 : 1) : 0);
    chk("busy", int'(busy), int'(m_act));
    chk("cnt_enable", int'(cnt_enable), int'(m_act && m_pos <= m_len));
    chk("done", int'(done), int'(m_act && m_pos == m_len + 1));
    chk("done_id", int'(done_id), int'(m_act && m_pos == m_len + 1 && m_id));
    chk("bounces", int'(bounces), m_bnc);
  end
  task automatic reset_all();
    @(negedge clk); rst = 1; c_rst = 1; req = 0; s_req = 0;
    @(negedge clk); rst = 0; c_rst = 0;
  endtask
  task automatic run_req(input logic [1:0] r, output int en_n, output int did);
    bit ok = 0;
    en_n = 0; did = -1;
    req = r;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (cnt_enable) en_n++;
      if (done) begin did = int'(done_id); req = 0; ok = 1; end
    end
    if (!ok) begin req = 0; chk("run_timeout", 0, 1); end
  endtask
  initial begin
    int en_n, did, k, dcyc, gap;
    int ids[4], exp_ids[4];
`ifdef PPS_ROUND_ROBIN_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_gnt", int'(gnt), 0); chk("rst_busy", int'(busy), 0); chk("rst_bounces", int'(bounces), 0);
    // run of 5 for requester 0
    reset_all(); len0 = 5;
    run_req(2'b01, en_n, did);
    chk("t1_enables", en_n, 5); chk("t1_out", int'(c_out), 5);
    chk("t1_bounces", int'(bounces), 0); chk("t1_done_id", did, 0);
    // run of 20 for requester 1: 1..15 then 14..10, one reversal
    reset_all(); len1 = 20;
    run_req(2'b10, en_n, did);
    chk("t2_enables", en_n, 20); chk("t2_out", int'(c_out), 10);
    chk("t2_bounces", int'(bounces), 1); chk("t2_done_id", did, 1);
    // both requesting continuously
    reset_all(); len0 = 3; len1 = 3; req = 2'b11;
    k = 0; dcyc = -1; gap = -1;
    for (int i = 0; i < 200 && k < 4; i++) begin
      @(negedge clk);
      if (cnt_enable && dcyc >= 0 && gap < 0) gap = i - dcyc;
      if (done) begin ids[k] = int'(done_id); k++; if (dcyc < 0) dcyc = i; end
    end
    req = 0;
    chk("t3_dones", k, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), ids[i], exp_ids[i]);
    chk("t3_gap", gap, 2);
    // zero-length run
    reset_all(); len0 = 0; req = 2'b01;
    @(negedge clk);
    chk("t4_gnt", int'(gnt), 1); chk("t4_done", int'(done), 1);
    chk("t4_done_id", int'(done_id), 0); chk("t4_enable", int'(cnt_enable), 0);
    req = 0;
    @(negedge clk);
    chk("t4_idle_busy", int'(busy), 0); chk("t4_idle_enable", int'(cnt_enable), 0);
    // reset mid-run with 4 steps remaining (7th RUN cycle of 10)
    reset_all(); len0 = 10; req = 2'b01;
    repeat (7) @(negedge clk);
    chk("t5_running", int'(cnt_enable), 1);
    rst = 1; req = 0;
    @(negedge clk);
    chk("t5_gnt", int'(gnt), 0); chk("t5_busy", int'(busy), 0);
    chk("t5_enable", int'(cnt_enable), 0); chk("t5_done", int'(done), 0);
    rst = 0; len0 = 2;
    run_req(2'b01, en_n, did);
    chk("t5_rerun_enables", en_n, 2); chk("t5_rerun_id", did, 0);
    // long run: 255 steps over a 0..15 counter reverses 16 times
    reset_all(); len0 = 255;
    run_req(2'b01, en_n, did);
    chk("t6_enables", en_n, 255); chk("t6_bounces", int'(bounces), 16);
    // 4-bit build with direction toggling every cycle: 16 counted cycles must saturate at 15
    reset_all(); s_len0 = 15; s_req = 2'b01;
    k = 0;
    for (int i = 0; i < 60 && k == 0; i++) begin
      @(negedge clk);
      s_dir = ~s_dir;
      if (s_done) begin k = 1; s_req = 0; end
    end
    chk("t7_done_seen", k, 1); chk("t7_saturated", int'(s_bounces), 15);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
